// File: rtl/addsub_bist_checker_pkg.sv
// Shared types and constants for the add/subtract BIST sequencer:
// FSM states, the directed vector table and the LFSR definition.
package addsub_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       op;
    } vec_t;

    localparam int          NUM_DIRECTED      = 10;
    // Fibonacci taps for x^16+x^14+x^13+x^11+1 (state bits 15,13,12,10)
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    // Directed vectors: four sign combinations of +/-13, +/-12 for add and
    // subtract, then the two add-overflow corners.
    function automatic vec_t directed_vec(input logic [3:0] i);
        case (i)
            4'd0:    return {8'h0D, 8'h0C, 1'b0};
            4'd1:    return {8'h0D, 8'hF4, 1'b0};
            4'd2:    return {8'hF3, 8'h0C, 1'b0};
            4'd3:    return {8'hF3, 8'hF4, 1'b0};
            4'd4:    return {8'h0D, 8'h0C, 1'b1};
            4'd5:    return {8'h0D, 8'hF4, 1'b1};
            4'd6:    return {8'hF3, 8'h0C, 1'b1};
            4'd7:    return {8'hF3, 8'hF4, 1'b1};
            4'd8:    return {8'h7F, 8'h7F, 1'b0};
            4'd9:    return {8'h81, 8'h81, 1'b0};
            default: return '0;
        endcase
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/addsub_bist_checker_if.sv
// Operand/result bus between the BIST checker and the adder under test.
interface addsub_bist_checker_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] dut_a;
    logic [WIDTH-1:0] dut_b;
    logic             dut_op;
    logic [WIDTH-1:0] dut_sum;
    logic             dut_overflow;

    modport master (
        output dut_a, dut_b, dut_op,
        input  dut_sum, dut_overflow
    );

    modport slave (
        input  dut_a, dut_b, dut_op,
        output dut_sum, dut_overflow
    );
endinterface

// File: rtl/addsub_bist_checker_golden.sv
// Combinational reference for a two's-complement adder/subtractor.
module addsub_golden #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic [WIDTH-1:0] exp_sum,
    output logic             exp_ovf
);
    // Wrap-around result and signed overflow from the operand/result sign bits
    always_comb begin
        exp_sum = op ? (a - b) : (a + b);
        if (op)
            exp_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (exp_sum[WIDTH-1] != a[WIDTH-1]);
        else
            exp_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (exp_sum[WIDTH-1] != a[WIDTH-1]);
    end
endmodule

// File: rtl/addsub_bist_checker.sv
// BIST sequencer/checker: walks the directed and LFSR vector set through the
// adder, compares each response with the golden model, counts errors and
// captures the first failing vector.
//
// state    | meaning
// ST_IDLE  | after reset, outputs held, waiting for start
// ST_DRIVE | vector on the bus, waiting DUT_LATENCY+1 cycles
// ST_CHECK | compare response, update counters, select next vector
// ST_DONE  | run finished, results frozen, start re-arms
module addsub_bist_checker
    import addsub_bist_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter int          NUM_RANDOM  = 16,
    parameter int          DUT_LATENCY = 0,
    parameter logic [15:0] LFSR_SEED   = LFSR_SEED_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    addsub_bist_checker_if.master dut_bus,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [7:0]            err_count,
    output logic [7:0]            vec_count,
    output logic [WIDTH-1:0]      fail_a,
    output logic [WIDTH-1:0]      fail_b,
    output logic                  fail_op,
    output logic [WIDTH-1:0]      fail_sum,
    output logic                  fail_ovf
);
    localparam logic [7:0] LAST_IDX = 8'(NUM_DIRECTED + NUM_RANDOM - 1);
    localparam logic [7:0] LAT_LOAD = 8'(DUT_LATENCY);
    localparam logic [7:0] DIR_END  = 8'(NUM_DIRECTED);

    state_t           state;
    logic [7:0]       idx;
    logic [15:0]      lfsr;
    logic [7:0]       lat_cnt;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_ovf;
    logic             mismatch;
    logic [7:0]       idx_nxt;
    logic [15:0]      lfsr_adv;
    vec_t             vec_first;
    vec_t             vec_next;

    addsub_golden #(.WIDTH(WIDTH)) u_golden (
        .a       (dut_bus.dut_a),
        .b       (dut_bus.dut_b),
        .op      (dut_bus.dut_op),
        .exp_sum (exp_sum),
        .exp_ovf (exp_ovf)
    );

    // Next vector: directed table first, then the LFSR; the LFSR only moves
    // after a random vector has been checked, so the first random vector is
    // the seed itself.
    always_comb begin
        mismatch  = (dut_bus.dut_sum != exp_sum) || (dut_bus.dut_overflow != exp_ovf);
        idx_nxt   = idx + 8'd1;
        lfsr_adv  = (idx >= DIR_END) ? lfsr_step(lfsr) : lfsr;
        vec_first = directed_vec(4'd0);
        if (idx_nxt < DIR_END)
            vec_next = directed_vec(idx_nxt[3:0]);
        else
            vec_next = {lfsr_adv[15:8], lfsr_adv[7:0], ^lfsr_adv};
    end

    // Sequencer FSM with registered bus and status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            idx            <= '0;
            lfsr           <= '0;
            lat_cnt        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            vec_count      <= '0;
            fail_a         <= '0;
            fail_b         <= '0;
            fail_op        <= 1'b0;
            fail_sum       <= '0;
            fail_ovf       <= 1'b0;
            dut_bus.dut_a  <= '0;
            dut_bus.dut_b  <= '0;
            dut_bus.dut_op <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state          <= ST_DRIVE;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_count      <= '0;
                        vec_count      <= '0;
                        fail_a         <= '0;
                        fail_b         <= '0;
                        fail_op        <= 1'b0;
                        fail_sum       <= '0;
                        fail_ovf       <= 1'b0;
                        idx            <= '0;
                        lfsr           <= LFSR_SEED;
                        lat_cnt        <= LAT_LOAD;
                        dut_bus.dut_a  <= vec_first.a;
                        dut_bus.dut_b  <= vec_first.b;
                        dut_bus.dut_op <= vec_first.op;
                    end else if (state == ST_DONE) begin
                        done <= 1'b1;
                        pass <= (err_count == 8'd0);
                    end
                end
                ST_DRIVE: begin
                    if (lat_cnt == 8'd0)
                        state <= ST_CHECK;
                    else
                        lat_cnt <= lat_cnt - 8'd1;
                end
                ST_CHECK: begin
                    vec_count <= vec_count + 8'd1;
                    if (mismatch) begin
                        if (err_count != 8'hFF)
                            err_count <= err_count + 8'd1;
                        if (err_count == 8'd0) begin
                            fail_a   <= dut_bus.dut_a;
                            fail_b   <= dut_bus.dut_b;
                            fail_op  <= dut_bus.dut_op;
                            fail_sum <= dut_bus.dut_sum;
                            fail_ovf <= dut_bus.dut_overflow;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                    end else begin
                        state          <= ST_DRIVE;
                        idx            <= idx_nxt;
                        lfsr           <= lfsr_adv;
                        lat_cnt        <= LAT_LOAD;
                        dut_bus.dut_a  <= vec_next.a;
                        dut_bus.dut_b  <= vec_next.b;
                        dut_bus.dut_op <= vec_next.op;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_bist_checker.sv
// Bench for addsub_bist_checker: four checker instances, each beside its own
// behavioural adder (correct, overflow stuck at 0, op ignored, 2-stage
// pipelined). Expected vectors are pushed to a queue at each start and popped
// as the checker presents them.
module tb_addsub_bist_checker;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       op;
    } tv_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] start_v;
    logic [3:0] busy_v, done_v, pass_v, fop_v, fovf_v, oop;
    logic [7:0] err_v [4];
    logic [7:0] vec_v [4];
    logic [7:0] fa_v  [4];
    logic [7:0] fb_v  [4];
    logic [7:0] fs_v  [4];
    logic [7:0] oa    [4];
    logic [7:0] ob    [4];
    logic [7:0] osum  [4];
    logic [3:0] oovf;

    int  errors = 0;
    int  checks = 0;
    tv_t exp_q[$];

    always #5 clk = ~clk;

    addsub_bist_checker_if bus0 ();
    addsub_bist_checker_if bus1 ();
    addsub_bist_checker_if bus2 ();
    addsub_bist_checker_if bus3 ();

    // behavioural adder: 9-bit sign-extended result, overflow when the top two bits differ
    function automatic logic [8:0] dut_fn(input logic [7:0] a, input logic [7:0] b, input logic op);
        logic [8:0] ea, eb, r;
        ea = {a[7], a};
        eb = {b[7], b};
        r  = op ? (ea - eb) : (ea + eb);
        return {r[8] ^ r[7], r[7:0]};
    endfunction

    logic [8:0] p1, p2;
    assign {bus0.dut_overflow, bus0.dut_sum} = dut_fn(bus0.dut_a, bus0.dut_b, bus0.dut_op);
    assign bus1.dut_sum      = bus1.dut_op ? (bus1.dut_a - bus1.dut_b) : (bus1.dut_a + bus1.dut_b);
    assign bus1.dut_overflow = 1'b0;
    assign {bus2.dut_overflow, bus2.dut_sum} = dut_fn(bus2.dut_a, bus2.dut_b, 1'b0);
    always @(posedge clk) begin
        p1 <= dut_fn(bus3.dut_a, bus3.dut_b, bus3.dut_op);
        p2 <= p1;
    end
    assign {bus3.dut_overflow, bus3.dut_sum} = p2;

    assign oa[0] = bus0.dut_a; assign ob[0] = bus0.dut_b; assign oop[0] = bus0.dut_op;
    assign oa[1] = bus1.dut_a; assign ob[1] = bus1.dut_b; assign oop[1] = bus1.dut_op;
    assign oa[2] = bus2.dut_a; assign ob[2] = bus2.dut_b; assign oop[2] = bus2.dut_op;
    assign oa[3] = bus3.dut_a; assign ob[3] = bus3.dut_b; assign oop[3] = bus3.dut_op;
    assign osum[0] = bus0.dut_sum; assign oovf[0] = bus0.dut_overflow;
    assign osum[1] = bus1.dut_sum; assign oovf[1] = bus1.dut_overflow;
    assign osum[2] = bus2.dut_sum; assign oovf[2] = bus2.dut_overflow;
    assign osum[3] = bus3.dut_sum; assign oovf[3] = bus3.dut_overflow;

    addsub_bist_checker #(.NUM_RANDOM(16), .DUT_LATENCY(0)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .dut_bus(bus0),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .err_count(err_v[0]), .vec_count(vec_v[0]),
        .fail_a(fa_v[0]), .fail_b(fb_v[0]), .fail_op(fop_v[0]),
        .fail_sum(fs_v[0]), .fail_ovf(fovf_v[0]));

    addsub_bist_checker #(.NUM_RANDOM(0), .DUT_LATENCY(0)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .dut_bus(bus1),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .err_count(err_v[1]), .vec_count(vec_v[1]),
        .fail_a(fa_v[1]), .fail_b(fb_v[1]), .fail_op(fop_v[1]),
        .fail_sum(fs_v[1]), .fail_ovf(fovf_v[1]));

    addsub_bist_checker #(.NUM_RANDOM(0), .DUT_LATENCY(0)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .dut_bus(bus2),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .err_count(err_v[2]), .vec_count(vec_v[2]),
        .fail_a(fa_v[2]), .fail_b(fb_v[2]), .fail_op(fop_v[2]),
        .fail_sum(fs_v[2]), .fail_ovf(fovf_v[2]));

    addsub_bist_checker #(.NUM_RANDOM(16), .DUT_LATENCY(2)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .dut_bus(bus3),
        .busy(busy_v[3]), .done(done_v[3]), .pass(pass_v[3]),
        .err_count(err_v[3]), .vec_count(vec_v[3]),
        .fail_a(fa_v[3]), .fail_b(fb_v[3]), .fail_op(fop_v[3]),
        .fail_sum(fs_v[3]), .fail_ovf(fovf_v[3]));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result using plain signed integer arithmetic: {ovf, sum}
    function automatic logic [8:0] ref_result(input tv_t v);
        int sa, sb, r;
        sa = int'($signed(v.a));
        sb = int'($signed(v.b));
        r  = v.op ? (sa - sb) : (sa + sb);
        return {(r > 127) || (r < -128), 8'(r)};
    endfunction

    task automatic push_vectors(input int nr);
        int          da [10] = '{13, 13, -13, -13, 13, 13, -13, -13, 127, -127};
        int          db [10] = '{12, -12, 12, -12, 12, -12, 12, -12, 127, -127};
        logic        dop[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
        logic [15:0] l;
        tv_t         v;
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            v.a  = 8'(da[i]);
            v.b  = 8'(db[i]);
            v.op = dop[i];
            exp_q.push_back(v);
        end
        l = 16'hACE1;
        for (int j = 0; j < nr; j++) begin
            v.a  = l[15:8];
            v.b  = l[7:0];
            v.op = ^l;
            exp_q.push_back(v);
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
    endtask

    task automatic check_reset(input int sel);
        check($sformatf("reset_status_u%0d", sel),
              {busy_v[sel], done_v[sel], pass_v[sel], err_v[sel], vec_v[sel]}, 64'd0);
        check($sformatf("reset_fail_u%0d", sel),
              {fa_v[sel], fb_v[sel], fop_v[sel], fs_v[sel], fovf_v[sel]}, 64'd0);
        check($sformatf("reset_bus_u%0d", sel), {oa[sel], ob[sel], oop[sel]}, 64'd0);
    endtask

    // One full run: start pulse, per-cycle vector and response checks, done timing
    task automatic run(input int sel, input int lat, input int nr, input bit chk_sum, input bit extra);
        int         nv;
        int         per;
        int         done_at;
        tv_t        cur;
        logic [8:0] rr;
        nv      = 10 + nr;
        per     = lat + 2;
        done_at = -1;
        cur     = '0;
        push_vectors(nr);
        @(posedge clk); #1 start_v[sel] = 1'b1;
        @(posedge clk); #1 start_v[sel] = 1'b0;
        for (int n = 0; n < nv * per + 20 && done_at < 0; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
            end
            if (n == 0 || n == nv * per)
                check($sformatf("busy_u%0d_n%0d", sel, n), busy_v[sel], (n == 0) ? 64'd1 : 64'd0);
            if (n < nv * per) begin
                if (n % per == 0) begin
                    check("sb_nonempty", exp_q.size() != 0, 64'd1);
                    if (exp_q.size() != 0)
                        cur = exp_q.pop_front();
                end
                check($sformatf("vec_u%0d_n%0d", sel, n), {oa[sel], ob[sel], oop[sel]}, cur);
                if (chk_sum && (n % per == per - 1)) begin
                    rr = ref_result(cur);
                    check($sformatf("resp_u%0d_n%0d", sel, n), {oovf[sel], osum[sel]}, rr);
                end
            end
            if (done_v[sel] && done_at < 0)
                done_at = n;
            if (extra)
                start_v[sel] = (n == 5 || n == 20);
        end
        start_v[sel] = 1'b0;
        check($sformatf("done_cycle_u%0d", sel), 64'(done_at), 64'(nv * per + 1));
        check("sb_drained", exp_q.size(), 64'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_v = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 4; s++)
            check_reset(s);
        rst_n = 1'b1;

        // overflow stuck at 0: the two add-overflow vectors fail
        run(1, 0, 0, 1'b0, 1'b0);
        check("u1_err", err_v[1], 64'd2);
        check("u1_pass", pass_v[1], 64'd0);
        check("u1_vec", vec_v[1], 64'd10);
        check("u1_fail", {fa_v[1], fb_v[1], fop_v[1], fs_v[1], fovf_v[1]},
              {8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0});

        // op ignored: all four subtract vectors fail
        run(2, 0, 0, 1'b0, 1'b0);
        check("u2_err", err_v[2], 64'd4);
        check("u2_fail", {fa_v[2], fb_v[2], fop_v[2], fs_v[2], fovf_v[2]},
              {8'h0D, 8'h0C, 1'b1, 8'h19, 1'b0});

        // pipelined adder with matching latency
        run(3, 2, 16, 1'b1, 1'b0);
        check("u3_pass", {pass_v[3], err_v[3], vec_v[3]}, {1'b1, 8'd0, 8'd26});

        // correct adder with stray start pulses mid-run
        run(0, 0, 16, 1'b1, 1'b1);
        check("u0_run1", {done_v[0], pass_v[0], err_v[0], vec_v[0]}, {1'b1, 1'b1, 8'd0, 8'd26});

        // back-to-back from DONE: LFSR reloads, same vectors and results
        run(0, 0, 16, 1'b1, 1'b0);
        check("u0_run2", {done_v[0], pass_v[0], err_v[0], vec_v[0]}, {1'b1, 1'b1, 8'd0, 8'd26});

        // reset mid-run discards everything
        @(posedge clk); #1 start_v[0] = 1'b1;
        @(posedge clk); #1 start_v[0] = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        check("u0_busy_before_rst", {busy_v[0], vec_v[0] != 8'd0}, {1'b1, 1'b1});
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset(0);
        rst_n = 1'b1;

        // clean run after the reset
        run(0, 0, 16, 1'b1, 1'b0);
        check("u0_run3", {done_v[0], pass_v[0], err_v[0], vec_v[0]}, {1'b1, 1'b1, 8'd0, 8'd26});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/addsub_bist_checker.md
# addsub_bist_checker

Built-in self-test sequencer and response checker for the 8-bit carry look-ahead adder/subtractor. It drives the adder's `a`/`b`/`op` inputs and samples its `sum`/`overflow` outputs. Each response is compared against a golden model, errors are counted, and the first failing vector is captured. The block sits beside the adder in the arithmetic datapath and gives a synthesizable, self-checking alternative to the simulation-only stimulus fixture.

## Interface
Parameters:
- `WIDTH`, 8: operand width (the block is verified at 8 only).
- `NUM_RANDOM`, 16: number of pseudo-random vectors that follow the directed set (0–245).
- `DUT_LATENCY`, 0: register stages inside the DUT between operands and result.
- `LFSR_SEED`, 16'hACE1: LFSR value loaded on every `start`; must be nonzero.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst_n`, in, 1: reset; synchronous, active-low.
- `start`, in, 1: one-cycle pulse that begins a run.
- `dut_a`, out, 8: operand A to the DUT.
- `dut_b`, out, 8: operand B to the DUT.
- `dut_op`, out, 1: operation to the DUT; 0 = add, 1 = subtract.
- `dut_sum`, in, 8: DUT result.
- `dut_overflow`, in, 1: DUT signed-overflow flag.
- `busy`, out, 1: high while a run is in progress.
- `done`, out, 1: high from the end of a run until the next accepted `start`.
- `pass`, out, 1: high when `done` is high and `err_count` is 0.
- `err_count`, out, 8: number of mismatching vectors; saturates at 255.
- `vec_count`, out, 8: number of vectors checked so far.
- `fail_a`, `fail_b`, out, 8 each: operands of the first failing vector.
- `fail_op`, out, 1: operation of the first failing vector.
- `fail_sum`, out, 8: DUT sum of the first failing vector.
- `fail_ovf`, out, 1: DUT overflow of the first failing vector.

## Operation
Vector set, V = 10 + NUM_RANDOM vectors, in order:
- Directed, add (`op`=0): (13,12), (13,−12), (−13,12), (−13,−12).
- Directed, subtract (`op`=1): the same four operand pairs.
- Directed, add overflow: (127,127), (−127,−127).
- Random: 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1. `a`=lfsr[15:8], `b`=lfsr[7:0], `op`=XOR-reduce(lfsr). The LFSR advances once per random vector.

Golden model, all arithmetic mod 256:
- exp_sum = op ? a − b : a + b.
- Add overflow: a[7]==b[7] and exp_sum[7]!=a[7].
- Subtract overflow: a[7]!=b[7] and exp_sum[7]!=a[7].
- The same rules hold for b = −128 with no special case.

A vector fails if `dut_sum` ≠ exp_sum or `dut_overflow` ≠ exp_ovf.

FSM states:
- IDLE: outputs held. `start` → DRIVE. The start also clears the counters, `fail_*` and `done`, loads LFSR_SEED and sets the vector index to 0.
- DRIVE: the vector is presented on `dut_*`. The state lasts DUT_LATENCY+1 cycles, then → CHECK.
- CHECK: one cycle. Compare, increment `vec_count`, and on a mismatch increment `err_count`. On the first mismatch of the run, capture `fail_*`. If index = V−1 → DONE; otherwise increment the index (and advance the LFSR for random vectors) and → DRIVE.
- DONE: `done`=1, results frozen. `start` → DRIVE, with the same clearing and loading as from IDLE.
- `start` during DRIVE or CHECK is ignored.

## Timing
- Reset state: FSM in IDLE. Every output is 0: `dut_a`, `dut_b`, `dut_op`, `busy`, `done`, `pass`, `err_count`, `vec_count`, all `fail_*`.
- `busy` is high exactly in DRIVE and CHECK.
- Each vector occupies DUT_LATENCY+2 cycles. `dut_*` are stable for all of them.
- `done` rises V·(DUT_LATENCY+2)+1 cycles after the edge that samples `start`. With defaults that is 53 cycles.
- Reset asserted mid-run: on the next edge, return to the full reset state. The partial results are discarded.
- `start` and the CHECK of the last vector in the same cycle: `start` is ignored. The block enters DONE.

## Structure
- Package `addsub_bist_pkg` holds:
  - the FSM state enum;
  - the directed vector table, 10 entries of {a, b, op};
  - the LFSR tap mask and default seed constant.
- Sub-module `addsub_golden` is combinational: (a, b, op) → (exp_sum, exp_ovf). It is reusable by the other arithmetic benches.

## Test plan
- Correct behavioural DUT, defaults: `done` at cycle 53, `pass`=1, `vec_count`=26, `err_count`=0. Directed expectations include:
  - 13+12 → 0x19, overflow 0.
  - −13−(−12) → 0xFF, overflow 0.
  - 127+127 → 0xFE, overflow 1.
  - −127+−127 → 0x02, overflow 1.
- DUT with overflow stuck at 0, NUM_RANDOM=0:
  - `err_count`=2, `pass`=0.
  - `fail_a`=0x7F, `fail_b`=0x7F, `fail_op`=0, `fail_sum`=0xFE, `fail_ovf`=0.
- DUT that ignores `op`, NUM_RANDOM=0:
  - `err_count`=4.
  - `fail_a`=0x0D, `fail_b`=0x0C, `fail_op`=1, `fail_sum`=0x19, `fail_ovf`=0.
- DUT_LATENCY=2 with a 2-stage registered DUT: `pass`=1, and `done` rises 105 cycles after `start`.
- Extra `start` pulses at cycles 5 and 20: ignored, and `done` still rises at cycle 53. `rst_n`=0 at cycle 30: all outputs are 0 on the next edge. A new `start` then gives a full clean run.
- Two back-to-back runs from DONE: identical random vectors (the LFSR reloads), and identical results.
